beer_draft_multi: RTL and testbench

- Parametrised successor to the single-tap beer draft controller.
- Serves NUM_TAPS taps from one operator panel. Panel inputs: `next` selects the tap; a rising edge on `draft` starts a timed pour.
- Per-tap level checking, mid-pour abort on low level, and a served-pour counter.
- Sits between the panel debouncers and the tap valve drivers / 7-segment state display.

---
 rtl/beer_draft_multi.sv | 132 +++++++++++++
 tb/tb_beer_draft_multi.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/beer_draft_multi.sv
// Multi-tap beer draft controller: operator panel edge detection, per-tap level
// check, timed pour with low-level abort, and a wrapping served-pour counter.
module beer_draft_multi #(
    parameter int NUM_TAPS    = 4,
    parameter int LEVEL_W     = 8,
    parameter int MIN_LEVEL   = 16,
    parameter int POUR_CYCLES = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          next,
    input  logic                          draft,
    input  logic [NUM_TAPS*LEVEL_W-1:0]   beer_level,
    output logic [NUM_TAPS-1:0]           beer,
    output logic [3:0]                    state_display,
    output logic [$clog2(NUM_TAPS)-1:0]   tap_sel,
    output logic                          empty,
    output logic [7:0]                    served_count
);

    localparam int TAP_W = $clog2(NUM_TAPS);
    localparam int CNT_W = (POUR_CYCLES > 1) ? $clog2(POUR_CYCLES) : 1;
    localparam logic [TAP_W-1:0]   LAST_TAP = TAP_W'(NUM_TAPS - 1);
    localparam logic [LEVEL_W-1:0] MIN_LVL  = LEVEL_W'(MIN_LEVEL);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(POUR_CYCLES - 1);

    // Enum values double as the display codes.
    typedef enum logic [3:0] {
        S_IDLE  = 4'h0,
        S_CHECK = 4'h1,
        S_POUR  = 4'h2,
        S_DONE  = 4'h3,
        S_EMPTY = 4'hE
    } state_t;

    state_t               state, state_nxt;
    logic [TAP_W-1:0]     tap_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [7:0]           served_nxt;
    logic                 next_r, draft_r;
    logic                 next_edge, draft_edge;
    logic [LEVEL_W-1:0]   levels [NUM_TAPS];
    logic [LEVEL_W-1:0]   sel_level;
    logic                 level_ok;

    function automatic logic [TAP_W-1:0] wrap_inc(input logic [TAP_W-1:0] t);
        return (t == LAST_TAP) ? '0 : t + 1'b1;
    endfunction

    for (genvar i = 0; i < NUM_TAPS; i++) begin : g_lvl
        assign levels[i] = beer_level[i*LEVEL_W +: LEVEL_W];
    end

    assign sel_level  = levels[tap_sel];
    assign level_ok   = (sel_level >= MIN_LVL);
    assign next_edge  = next & ~next_r;
    assign draft_edge = draft & ~draft_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            tap_sel      <= '0;
            cnt          <= '0;
            served_count <= '0;
            next_r       <= 1'b0;
            draft_r      <= 1'b0;
        end else begin
            state        <= state_nxt;
            tap_sel      <= tap_nxt;
            cnt          <= cnt_nxt;
            served_count <= served_nxt;
            next_r       <= next;
            draft_r      <= draft;
        end
    end

    always_comb begin
        state_nxt  = state;
        tap_nxt    = tap_sel;
        cnt_nxt    = cnt;
        served_nxt = served_count;
        case (state)
            S_IDLE: begin
                // A draft edge takes priority over a simultaneous next edge.
                if (draft_edge)
                    state_nxt = S_CHECK;
                else if (next_edge)
                    tap_nxt = wrap_inc(tap_sel);
            end
            S_CHECK: begin
                if (level_ok) begin
                    state_nxt = S_POUR;
                    cnt_nxt   = CNT_LOAD;
                end else begin
                    state_nxt = S_EMPTY;
                end
            end
            S_POUR: begin
                if (!level_ok) begin
                    state_nxt = S_EMPTY;
                end else if (cnt == '0) begin
                    state_nxt  = S_DONE;
                    served_nxt = served_count + 8'd1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_DONE: begin
                // Holding draft keeps us here so one request yields one pour.
                if (!draft)
                    state_nxt = S_IDLE;
            end
            S_EMPTY: begin
                if (next_edge) begin
                    state_nxt = S_IDLE;
                    tap_nxt   = wrap_inc(tap_sel);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        beer = '0;
        if (state == S_POUR)
            beer[tap_sel] = 1'b1;
    end

    assign state_display = state;
    assign empty         = (state == S_EMPTY);

endmodule

// File: tb/tb_beer_draft_multi.sv
// Bench for beer_draft_multi: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural reference model.
module tb_beer_draft_multi;

    localparam int NUM_TAPS    = 4;
    localparam int LEVEL_W     = 8;
    localparam int MIN_LEVEL   = 16;
    localparam int POUR_CYCLES = 10;
    localparam int TAP_W       = $clog2(NUM_TAPS);

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        next;
    logic                        draft;
    logic [NUM_TAPS*LEVEL_W-1:0] beer_level;
    logic [NUM_TAPS-1:0]         beer;
    logic [3:0]                  state_display;
    logic [TAP_W-1:0]            tap_sel;
    logic                        empty;
    logic [7:0]                  served_count;

    beer_draft_multi #(
        .NUM_TAPS(NUM_TAPS), .LEVEL_W(LEVEL_W),
        .MIN_LEVEL(MIN_LEVEL), .POUR_CYCLES(POUR_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .next(next), .draft(draft),
        .beer_level(beer_level), .beer(beer), .state_display(state_display),
        .tap_sel(tap_sel), .empty(empty), .served_count(served_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: modes named by meaning, pour tracked as cycles remaining.
    localparam int M_IDLE = 0, M_CHECK = 1, M_POUR = 2, M_DONE = 3, M_EMPTY = 4;
    int m_mode, m_sel, m_served, m_left;
    bit m_pn, m_pd;

    function automatic int lvl(input int t);
        return int'(beer_level[t*LEVEL_W +: LEVEL_W]);
    endfunction

    function automatic int disp_of(input int mode);
        case (mode)
            M_IDLE:  return 0;
            M_CHECK: return 1;
            M_POUR:  return 2;
            M_DONE:  return 3;
            default: return 14;
        endcase
    endfunction

    task automatic model_edge();
        bit ne, de;
        if (!reset) begin
            m_mode = M_IDLE; m_sel = 0; m_served = 0; m_left = 0;
            m_pn = 0; m_pd = 0;
            return;
        end
        ne = next && !m_pn;
        de = draft && !m_pd;
        case (m_mode)
            M_IDLE:  if (de) m_mode = M_CHECK;
                     else if (ne) m_sel = (m_sel + 1) % NUM_TAPS;
            M_CHECK: if (lvl(m_sel) >= MIN_LEVEL) begin
                         m_mode = M_POUR; m_left = POUR_CYCLES;
                     end else m_mode = M_EMPTY;
            M_POUR:  if (lvl(m_sel) < MIN_LEVEL) m_mode = M_EMPTY;
                     else begin
                         m_left--;
                         if (m_left == 0) begin
                             m_mode = M_DONE; m_served = (m_served + 1) % 256;
                         end
                     end
            M_DONE:  if (!draft) m_mode = M_IDLE;
            default: if (ne) begin m_mode = M_IDLE; m_sel = (m_sel + 1) % NUM_TAPS; end
        endcase
        m_pn = next; m_pd = draft;
    endtask

    task automatic compare_model(input string tag);
        logic [31:0] exp_beer;
        exp_beer = (m_mode == M_POUR) ? (32'd1 << m_sel) : 32'd0;
        chk({tag, " disp"},   32'(state_display), 32'(disp_of(m_mode)));
        chk({tag, " beer"},   32'(beer),          exp_beer);
        chk({tag, " sel"},    32'(tap_sel),       32'(m_sel));
        chk({tag, " served"}, 32'(served_count),  32'(m_served));
        chk({tag, " empty"},  32'(empty),         32'(m_mode == M_EMPTY));
    endtask

    task automatic set_in(input bit r, input bit n, input bit d);
        reset = r; next = n; draft = d;
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic set_level(input int t, input int v);
        beer_level[t*LEVEL_W +: LEVEL_W] = LEVEL_W'(v);
    endtask

    typedef struct {
        bit         rst_n;
        bit         nx;
        bit         dr;
        logic [3:0] disp;
        int         sel;
        logic [3:0] bm;
        int         srv;
        bit         emp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit n, input bit d, input logic [3:0] disp,
                                input int sel, input logic [3:0] bm, input int srv, input bit e);
        vec_t v;
        v = '{r, n, d, disp, sel, bm, srv, e};
        tbl.push_back(v);
    endfunction

    initial begin
        int saved;
        set_in(0, 0, 0);
        beer_level = {NUM_TAPS{8'd100}};

        // Tap stepping, wrap, then a full pour on tap 1 with draft held into DONE.
        add(0,0,0,4'h0,0,4'b0000,0,0);
        add(1,1,0,4'h0,1,4'b0000,0,0); add(1,0,0,4'h0,1,4'b0000,0,0);
        add(1,1,0,4'h0,2,4'b0000,0,0); add(1,0,0,4'h0,2,4'b0000,0,0);
        add(1,1,0,4'h0,3,4'b0000,0,0); add(1,0,0,4'h0,3,4'b0000,0,0);
        add(1,1,0,4'h0,0,4'b0000,0,0); add(1,0,0,4'h0,0,4'b0000,0,0);
        add(1,1,0,4'h0,1,4'b0000,0,0); add(1,0,0,4'h0,1,4'b0000,0,0);
        add(1,0,1,4'h1,1,4'b0000,0,0);
        for (int i = 0; i < POUR_CYCLES; i++) add(1,0,1,4'h2,1,4'b0010,0,0);
        add(1,0,1,4'h3,1,4'b0000,1,0);
        add(1,0,1,4'h3,1,4'b0000,1,0);
        add(1,0,0,4'h0,1,4'b0000,1,0);

        foreach (tbl[i]) begin
            set_in(tbl[i].rst_n, tbl[i].nx, tbl[i].dr);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d disp", i),   32'(state_display), 32'(tbl[i].disp));
            chk($sformatf("tbl%0d sel", i),    32'(tap_sel),       32'(tbl[i].sel));
            chk($sformatf("tbl%0d beer", i),   32'(beer),          32'(tbl[i].bm));
            chk($sformatf("tbl%0d served", i), 32'(served_count),  32'(tbl[i].srv));
            chk($sformatf("tbl%0d empty", i),  32'(empty),         32'(tbl[i].emp));
        end

        // Low level at check time goes to EMPTY; next acknowledges and advances.
        set_in(0, 0, 0); cycle("p3 rst");
        set_in(1, 1, 0); cycle("p3 n1"); set_in(1, 0, 0); cycle("p3 n1r");
        set_in(1, 1, 0); cycle("p3 n2"); set_in(1, 0, 0); cycle("p3 n2r");
        set_level(2, 15);
        set_in(1, 0, 1); cycle("p3 d");
        set_in(1, 0, 0);
        for (int i = 0; i < 4; i++) cycle("p3 wait");
        chk("p3 empty", 32'(empty), 32'd1);
        chk("p3 disp", 32'(state_display), 32'hE);
        set_in(1, 0, 1); cycle("p3 d ignored");
        set_in(1, 1, 0); cycle("p3 ack"); set_in(1, 0, 0); cycle("p3 ackr");
        chk("p3 sel after ack", 32'(tap_sel), 32'd3);
        chk("p3 idle", 32'(state_display), 32'h0);

        // Level drops during the 5th pour cycle.
        beer_level = {NUM_TAPS{8'd100}};
        set_in(0, 0, 0); cycle("p4 rst");
        set_in(1, 0, 1); cycle("p4 d");
        set_in(1, 0, 0);
        for (int i = 0; i < 5; i++) cycle("p4 pour");
        chk("p4 pouring", 32'(beer), 32'b0001);
        saved = int'(served_count);
        set_level(0, 10);
        cycle("p4 drop");
        chk("p4 beer off", 32'(beer), 32'd0);
        chk("p4 disp", 32'(state_display), 32'hE);
        chk("p4 served kept", 32'(served_count), 32'(saved));
        set_level(0, 100);
        set_in(1, 1, 0); cycle("p4 ack"); set_in(1, 0, 0); cycle("p4 ackr");

        // Simultaneous edges: draft wins; held draft gives exactly one pour.
        set_in(0, 0, 0); cycle("p5 rst");
        set_in(1, 1, 1); cycle("p5 both");
        chk("p5 check", 32'(state_display), 32'h1);
        set_in(1, 0, 1);
        for (int i = 0; i < 25; i++) cycle("p5 hold");
        chk("p5 sel", 32'(tap_sel), 32'd0);
        chk("p5 done hold", 32'(state_display), 32'h3);
        set_in(1, 0, 0); cycle("p5 rel");
        for (int i = 0; i < 3; i++) cycle("p5 idle");
        chk("p5 served", 32'(served_count), 32'd1);

        // Reset in the 3rd pour cycle of tap 1.
        set_in(1, 1, 0); cycle("p6 n"); set_in(1, 0, 0); cycle("p6 nr");
        set_in(1, 0, 1); cycle("p6 d"); set_in(1, 0, 0);
        for (int i = 0; i < 3; i++) cycle("p6 pour");
        chk("p6 pouring", 32'(beer), 32'b0010);
        set_in(0, 0, 0); cycle("p6 rst");
        chk("p6 beer", 32'(beer), 32'd0);
        chk("p6 disp", 32'(state_display), 32'h0);
        chk("p6 sel", 32'(tap_sel), 32'd0);
        chk("p6 served", 32'(served_count), 32'd0);

        // 256 completed pours wrap the counter.
        set_in(1, 0, 0); cycle("wrap start");
        for (int p = 0; p < 256; p++) begin
            set_in(1, 0, 1); cycle("wrap d");
            set_in(1, 0, 0);
            for (int i = 0; i < POUR_CYCLES + 2; i++) cycle("wrap run");
            if (p == 254) chk("wrap 255", 32'(served_count), 32'd255);
        end
        chk("wrap 0", 32'(served_count), 32'd0);

        // Randomized traffic with occasional level changes and resets.
        for (int c = 0; c < 4000; c++) begin
            set_in(($urandom % 200) != 0, ($urandom % 3) == 0, ($urandom % 4) == 0);
            if (($urandom % 8) == 0)
                set_level($urandom % NUM_TAPS,
                          (($urandom % 2) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 255));
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
